// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch request controller.
//
// Issues sequential PC fetches on an SRAM-like instruction port (one request
// outstanding at most), discards responses made stale by a redirect, and
// buffers returned {pc, inst} pairs in a small FIFO that feeds decode through
// a valid/allowin handshake.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   redirect_valid/pc    branch/exception redirect pulse and target
//   fs_allowin           downstream can take the buffer head this cycle
//   fs_valid/pc/inst     buffer head (combinational)
//   inst_sram_*          request side towards the CPU-to-AXI bridge
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter int unsigned IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fs_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok
);

  localparam int unsigned PtrW = $clog2(IBUF_DEPTH);
  localparam int unsigned CntW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(IBUF_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     out_pc_q, out_pc_d;
  logic            cancel_q, cancel_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] buf_pc_q   [IBUF_DEPTH];
  logic [31:0] buf_inst_q [IBUF_DEPTH];

  logic        push;
  logic        pop;
  logic        enter_req;
  logic [31:0] pc_src;

  // Write side of the port is never used.
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  assign inst_sram_req  = (state_q == StReq);
  assign inst_sram_addr = req_addr_q;

  // A redirect hides the head in the same cycle, since the buffer is flushed.
  assign fs_valid = (count_q != '0) && !redirect_valid;
  assign fs_pc    = buf_pc_q[rd_ptr_q];
  assign fs_inst  = buf_inst_q[rd_ptr_q];

  assign pop  = fs_valid && fs_allowin;
  // A response coinciding with a redirect is stale by definition.
  assign push = (state_q == StWait) && inst_sram_data_ok && !cancel_q && !redirect_valid;

  // A redirect target takes effect for any request entered in the same cycle.
  assign pc_src = redirect_valid ? redirect_pc : fetch_pc_q;

  // Buffer occupancy and pointers.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Request FSM.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = redirect_valid ? redirect_pc : fetch_pc_q;
    req_addr_d = req_addr_q;
    out_pc_d   = out_pc_q;
    cancel_d   = cancel_q;
    enter_req  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Redirect flushes the buffer, so a slot is always free then.
        if (redirect_valid || (count_q < DepthCnt)) begin
          enter_req = 1'b1;
        end
      end
      StReq: begin
        // Address is held until accepted; the response it produces is dropped.
        if (redirect_valid) begin
          cancel_d = 1'b1;
        end
        if (inst_sram_addr_ok) begin
          out_pc_d = req_addr_q;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (inst_sram_data_ok) begin
          // The only outstanding response has returned; nothing left to cancel.
          cancel_d = 1'b0;
          if (count_d < DepthCnt) begin
            enter_req = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (redirect_valid) begin
          cancel_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (enter_req) begin
      state_d    = StReq;
      req_addr_d = pc_src;
      fetch_pc_d = pc_src + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      out_pc_q   <= RESET_PC;
      cancel_q   <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      out_pc_q   <= out_pc_d;
      cancel_q   <= cancel_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they exist.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= out_pc_q;
      buf_inst_q[wr_ptr_q] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fs_allowin;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_ctrl #(
    .RESET_PC  (32'hbfc00000),
    .IBUF_DEPTH(2)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fs_allowin       (fs_allowin),
    .fs_valid         (fs_valid),
    .fs_pc            (fs_pc),
    .fs_inst          (fs_inst),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Instruction word the bench's memory returns for an address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h9bc80001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn            = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    fs_allowin        = 1'b0;
    inst_sram_rdata   = 32'h0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Bridge model for one request: wait for req, accept after a_lat cycles,
  // return data d_lat cycles after acceptance.
  task automatic serve(input int a_lat, input int d_lat, output logic [31:0] a);
    int n;
    n = 0;
    while (!inst_sram_req && n < 20) begin
      tick();
      n++;
    end
    if (!inst_sram_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL serve_timeout: got req=%b expected req=1 within 20 cycles", inst_sram_req);
    end
    a = inst_sram_addr;
    repeat (a_lat) tick();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    repeat (d_lat) tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = inst_of(a);
    tick();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (inst_sram_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %b expected 0", inst_sram_req);
    end
    n_checks++;
    if (fs_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_fs_valid: got %b expected 0", fs_valid);
    end
    n_checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL tied_outputs: got wr=%b size=%b wstrb=%h wdata=%h expected 0 10 0 0",
               inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
    tick();
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'hbfc00000}) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h expected 1 bfc00000", inst_sram_req,
               inst_sram_addr);
    end
  endtask

  task automatic test_basic();
    do_reset();
    fs_allowin = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'hbfc00000}) begin
        n_fail++;
        $display("FAIL basic_req_hold: got req=%b addr=%h expected 1 bfc00000", inst_sram_req,
                 inst_sram_addr);
      end
      tick();
    end
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    n_checks++;
    if (inst_sram_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_wait_req: got %b expected 0", inst_sram_req);
    end
    tick();
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h24080001;
    tick();
    inst_sram_data_ok = 1'b0;
    n_checks++;
    if ({fs_valid, fs_pc, fs_inst} !== {1'b1, 32'hbfc00000, 32'h24080001}) begin
      n_fail++;
      $display("FAIL basic_head: got v=%b pc=%h inst=%h expected 1 bfc00000 24080001", fs_valid,
               fs_pc, fs_inst);
    end
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'hbfc00004}) begin
      n_fail++;
      $display("FAIL basic_next_req: got req=%b addr=%h expected 1 bfc00004", inst_sram_req,
               inst_sram_addr);
    end
    tick();
    n_checks++;
    if (fs_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_popped: got fs_valid=%b expected 0", fs_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    do_reset();
    serve(1, 1, a);
    serve(0, 2, a);
    n_checks++;
    if (a !== 32'hbfc00004) begin
      n_fail++; $display("FAIL bp_second_addr: got %h expected bfc00004", a);
    end
    for (int i = 0; i < 4; i++) begin
      // Stray handshake pulses while idle must be ignored.
      inst_sram_addr_ok = (i == 1);
      inst_sram_data_ok = (i == 2);
      inst_sram_rdata   = 32'hdeadbeef;
      tick();
      n_checks++;
      if ({inst_sram_req, fs_valid, fs_pc} !== {1'b0, 1'b1, 32'hbfc00000}) begin
        n_fail++;
        $display("FAIL bp_full_idle: got req=%b v=%b pc=%h expected 0 1 bfc00000", inst_sram_req,
                 fs_valid, fs_pc);
      end
    end
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    fs_allowin = 1'b1;
    tick();
    fs_allowin = 1'b0;
    n_checks++;
    if ({inst_sram_req, fs_valid, fs_pc, fs_inst} !== {1'b0, 1'b1, 32'hbfc00004, inst_of(32'hbfc00004)}) begin
      n_fail++;
      $display("FAIL bp_after_pop: got req=%b v=%b pc=%h inst=%h expected 0 1 bfc00004 %h",
               inst_sram_req, fs_valid, fs_pc, fs_inst, inst_of(32'hbfc00004));
    end
    tick();
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'hbfc00008}) begin
      n_fail++;
      $display("FAIL bp_resume_req: got req=%b addr=%h expected 1 bfc00008", inst_sram_req,
               inst_sram_addr);
    end
    fs_allowin = 1'b1;
    tick();
    fs_allowin = 1'b0;
    n_checks++;
    if (fs_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_two_entries_only: got fs_valid=%b expected 0", fs_valid);
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] a;
    do_reset();
    serve(0, 0, a);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80001000;
    #1;
    n_checks++;
    if (fs_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw_mask_valid: got %b expected 0", fs_valid);
    end
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({fs_valid, inst_sram_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL rw_flushed: got v=%b req=%b expected 0 0", fs_valid, inst_sram_req);
    end
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = inst_of(32'hbfc00004);
    tick();
    inst_sram_data_ok = 1'b0;
    n_checks++;
    if ({fs_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, 32'h80001000}) begin
      n_fail++;
      $display("FAIL rw_dropped: got v=%b req=%b addr=%h expected 0 1 80001000", fs_valid,
               inst_sram_req, inst_sram_addr);
    end
    serve(0, 1, a);
    n_checks++;
    if ({fs_valid, fs_pc, fs_inst} !== {1'b1, 32'h80001000, inst_of(32'h80001000)}) begin
      n_fail++;
      $display("FAIL rw_target_head: got v=%b pc=%h inst=%h expected 1 80001000 %h", fs_valid,
               fs_pc, fs_inst, inst_of(32'h80001000));
    end
    n_checks++;
    if (inst_sram_addr !== 32'h80001004) begin
      n_fail++; $display("FAIL rw_seq_after: got %h expected 80001004", inst_sram_addr);
    end
  endtask

  task automatic test_redirect_req();
    logic [31:0] a;
    do_reset();
    serve(0, 0, a);
    // Data pulse while requesting is spurious.
    inst_sram_data_ok = 1'b1;
    redirect_valid    = 1'b1;
    redirect_pc       = 32'h80002000;
    tick();
    inst_sram_data_ok = 1'b0;
    redirect_valid    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({inst_sram_req, inst_sram_addr, fs_valid} !== {1'b1, 32'hbfc00004, 1'b0}) begin
        n_fail++;
        $display("FAIL rr_addr_held: got req=%b addr=%h v=%b expected 1 bfc00004 0",
                 inst_sram_req, inst_sram_addr, fs_valid);
      end
      tick();
    end
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = inst_of(32'hbfc00004);
    tick();
    inst_sram_data_ok = 1'b0;
    n_checks++;
    if ({fs_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, 32'h80002000}) begin
      n_fail++;
      $display("FAIL rr_dropped: got v=%b req=%b addr=%h expected 0 1 80002000", fs_valid,
               inst_sram_req, inst_sram_addr);
    end
    serve(1, 0, a);
    n_checks++;
    if ({fs_valid, fs_pc} !== {1'b1, 32'h80002000}) begin
      n_fail++;
      $display("FAIL rr_target_head: got v=%b pc=%h expected 1 80002000", fs_valid, fs_pc);
    end
  endtask

  task automatic test_redirect_data_ok();
    logic [31:0] a;
    do_reset();
    serve(0, 0, a);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    tick();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = inst_of(32'hbfc00004);
    redirect_valid    = 1'b1;
    redirect_pc       = 32'h80003000;
    tick();
    inst_sram_data_ok = 1'b0;
    redirect_valid    = 1'b0;
    n_checks++;
    if ({fs_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, 32'h80003000}) begin
      n_fail++;
      $display("FAIL rd_coincident: got v=%b req=%b addr=%h expected 0 1 80003000", fs_valid,
               inst_sram_req, inst_sram_addr);
    end
    serve(0, 0, a);
    n_checks++;
    if ({fs_valid, fs_pc, fs_inst} !== {1'b1, 32'h80003000, inst_of(32'h80003000)}) begin
      n_fail++;
      $display("FAIL rd_no_stale_cancel: got v=%b pc=%h inst=%h expected 1 80003000 %h",
               fs_valid, fs_pc, fs_inst, inst_of(32'h80003000));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] head;
    int n;
    do_reset();
    serve(0, 0, a);
    for (int i = 0; i < 10; i++) begin
      head = 32'hbfc00000 + 32'(4 * i);
      n = 0;
      while (!inst_sram_req && n < 20) begin
        tick();
        n++;
      end
      n_checks++;
      if ({inst_sram_req, inst_sram_addr} !== {1'b1, head + 32'd4}) begin
        n_fail++;
        $display("FAIL b2b_req[%0d]: got req=%b addr=%h expected 1 %h", i, inst_sram_req,
                 inst_sram_addr, head + 32'd4);
      end
      inst_sram_addr_ok = 1'b1;
      tick();
      inst_sram_addr_ok = 1'b0;
      tick();
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(head + 32'd4);
      fs_allowin        = 1'b1;
      n_checks++;
      if ({fs_valid, fs_pc} !== {1'b1, head}) begin
        n_fail++;
        $display("FAIL b2b_pop[%0d]: got v=%b pc=%h expected 1 %h", i, fs_valid, fs_pc, head);
      end
      tick();
      inst_sram_data_ok = 1'b0;
      fs_allowin        = 1'b0;
      n_checks++;
      if ({fs_valid, fs_pc, fs_inst, inst_sram_req} !==
          {1'b1, head + 32'd4, inst_of(head + 32'd4), 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_count1[%0d]: got v=%b pc=%h inst=%h req=%b expected 1 %h %h 1", i,
                 fs_valid, fs_pc, fs_inst, inst_sram_req, head + 32'd4, inst_of(head + 32'd4));
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] a;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hfffffffc;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'hfffffffc}) begin
      n_fail++;
      $display("FAIL wrap_first: got req=%b addr=%h expected 1 fffffffc", inst_sram_req,
               inst_sram_addr);
    end
    serve(0, 0, a);
    n_checks++;
    if ({fs_pc, inst_sram_req, inst_sram_addr} !== {32'hfffffffc, 1'b1, 32'h00000000}) begin
      n_fail++;
      $display("FAIL wrap_next: got pc=%h req=%b addr=%h expected fffffffc 1 00000000", fs_pc,
               inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] a;
    do_reset();
    serve(0, 0, a);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    do_reset();
    n_checks++;
    if ({inst_sram_req, fs_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_clear: got req=%b v=%b expected 0 0", inst_sram_req, fs_valid);
    end
    tick();
    n_checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'hbfc00000}) begin
      n_fail++;
      $display("FAIL midrst_restart: got req=%b addr=%h expected 1 bfc00000", inst_sram_req,
               inst_sram_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_data_ok();
    test_back_to_back();
    test_pc_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
